// File: rtl/uart_rx_drain.sv
// uart_rx_drain: drains the 8N1 rx FIFO, packs bytes into 32-bit words, flushes on idle timeout or disable
module uart_rx_drain #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      divp_in,
  input  logic [TMO_W-1:0] tmo,
  output logic             rxen_n,
  output logic [15:0]      divp,
  output logic             rdrxd,
  input  logic [7:0]       dat,
  input  logic             rxempty,
  input  logic             rxfull,
  output logic [31:0]      wdata,
  output logic [2:0]       wcnt,
  output logic             wvalid,
  input  logic             wready,
  output logic             ovf,
  input  logic             ovf_clr
);
  typedef enum logic [1:0] {IDLE, POP, CAPT, EMIT} state_t;
  state_t           state;
  logic [2:0]       bcnt;
  logic [TMO_W-1:0] tcnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      bcnt   <= '0;
      tcnt   <= '0;
      rxen_n <= 1'b1;
      divp   <= '0;
      rdrxd  <= 1'b0;
      wdata  <= '0;
      wcnt   <= '0;
      wvalid <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      rxen_n <= ~en;
      if (!en) divp <= divp_in;
      ovf   <= rxfull | (ovf & ~ovf_clr);
      rdrxd <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= (bcnt == 3'd0) ? '0 : (&tcnt ? tcnt : tcnt + TMO_W'(1));
          if (en && !rxempty && bcnt < 3'd4) begin
            state <= POP;
            rdrxd <= 1'b1;
          end else if (bcnt == 3'd4 || (bcnt != 3'd0 && ((tmo != '0 && tcnt == tmo) || !en))) begin
            state  <= EMIT;
            wvalid <= 1'b1;
            wcnt   <= bcnt;
          end
        end
        POP: state <= CAPT;
        // dat is valid the cycle after the pop strobe
        CAPT: begin
          wdata[{bcnt[1:0], 3'b000} +: 8] <= dat;
          bcnt  <= bcnt + 3'd1;
          tcnt  <= '0;
          state <= IDLE;
        end
        EMIT: if (wready) begin
          wvalid <= 1'b0;
          wcnt   <= '0;
          wdata  <= '0;
          bcnt   <= '0;
          tcnt   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_drain.sv
// tb_uart_rx_drain: FIFO model, config/ovf vector table, corner sequences and a randomized byte scoreboard
module tb_uart_rx_drain;
  logic clk = 0, rst = 1, en = 0, wready = 1, ovf_clr = 0, ffull = 0, qfull = 0, rxempty = 1;
  logic rdrxd, wvalid, ovf, rxen_n, rxfull;
  logic [15:0] divp_in = 0, divp, tmo = 0;
  logic [7:0] dat = 0;
  logic [31:0] wdata;
  logic [2:0] wcnt;
  int checks = 0, errors = 0, pops = 0, cyc = 0, last_pop = 0;
  bit sb_on = 0;
  logic [7:0] q[$], exp_q[$];
  logic pv = 0, pr = 0, prd = 0;
  logic [31:0] pd = 0;
  logic [2:0] pc = 0;
  typedef struct {logic en; logic [15:0] din; logic full, clr; logic [15:0] ediv; logic erxn, eovf;} vec_t;
  vec_t tv[9];

  assign rxfull = ffull | qfull;

  uart_rx_drain #(.TMO_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .divp_in(divp_in), .tmo(tmo), .rxen_n(rxen_n), .divp(divp),
    .rdrxd(rdrxd), .dat(dat), .rxempty(rxempty), .rxfull(rxfull), .wdata(wdata), .wcnt(wcnt),
    .wvalid(wvalid), .wready(wready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    if (sb_on) exp_q.push_back(b);
  endtask

  task automatic wait_wvalid(input string n);
    for (int i = 0; i < 300 && !wvalid; i++) @(negedge clk);
    chk(n, wvalid, 1);
  endtask

  // FIFO model, pop legality, EMIT stability and word scoreboard
  always @(negedge clk) begin
    logic [8:0] eb;
    if (rst && pv && !pr) begin
      chk("hold_wvalid", wvalid, 1);
      chk("hold_wdata", wdata, pd);
      chk("hold_wcnt", wcnt, pc);
    end
    if (rdrxd) begin
      chk("pop_legal", {prd, wvalid, q.size() == 0}, 0);
      if (q.size() > 0) dat = q.pop_front();
      pops++;
      last_pop = cyc;
    end
    if (sb_on && wvalid && wready) begin
      chk("sb_wcnt_range", (wcnt >= 1 && wcnt <= 4), 1);
      for (int i = 0; i < 4; i++)
        if (i < wcnt) begin
          if (exp_q.size() > 0) eb = {1'b0, exp_q.pop_front()};
          else eb = 9'h100;
          chk("sb_byte", {1'b0, wdata[8*i +: 8]}, eb);
        end else chk("sb_pad", wdata[8*i +: 8], 0);
    end
    pv = wvalid; pr = wready; pd = wdata; pc = wcnt; prd = rdrxd;
    rxempty = (q.size() == 0);
    qfull = (q.size() >= 15);
  end

  initial begin
    int n, p0, sent;
    tv[0] = '{1'b0, 16'd434, 1'b0, 1'b0, 16'd434, 1'b1, 1'b0};
    tv[1] = '{1'b1, 16'd434, 1'b0, 1'b0, 16'd434, 1'b0, 1'b0};
    tv[2] = '{1'b1, 16'd100, 1'b0, 1'b0, 16'd434, 1'b0, 1'b0};
    tv[3] = '{1'b1, 16'd100, 1'b1, 1'b0, 16'd434, 1'b0, 1'b1};
    tv[4] = '{1'b1, 16'd100, 1'b0, 1'b0, 16'd434, 1'b0, 1'b1};
    tv[5] = '{1'b1, 16'd100, 1'b1, 1'b1, 16'd434, 1'b0, 1'b1};
    tv[6] = '{1'b1, 16'd100, 1'b0, 1'b1, 16'd434, 1'b0, 1'b0};
    tv[7] = '{1'b0, 16'd100, 1'b0, 1'b0, 16'd100, 1'b1, 1'b0};
    tv[8] = '{1'b0, 16'd7,   1'b0, 1'b1, 16'd7,   1'b1, 1'b0};
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rxen_n", rxen_n, 1);
    chk("rst_divp", divp, 0);
    chk("rst_rdrxd", rdrxd, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wcnt", wcnt, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1;
    for (int i = 0; i < 9; i++) begin
      en = tv[i].en; divp_in = tv[i].din; ffull = tv[i].full; ovf_clr = tv[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_divp", i), divp, tv[i].ediv);
      chk($sformatf("tv%0d_rxen_n", i), rxen_n, tv[i].erxn);
      chk($sformatf("tv%0d_ovf", i), ovf, tv[i].eovf);
    end
    ffull = 0; ovf_clr = 0;
    en = 1;
    #1 chk("rxen_n_lag", rxen_n, 1);
    divp_in = 16'd100;
    @(posedge clk);
    #1;
    chk("rxen_n_on", rxen_n, 0);
    chk("divp_frozen", divp, 7);
    // four bytes, immediate full-word emit
    pops = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_wvalid("A_seen");
    chk("A_wdata", wdata, 32'h44332211);
    chk("A_wcnt", wcnt, 4);
    chk("A_pops", pops, 4);
    @(negedge clk);
    chk("A_one_cycle", wvalid, 0);
    // idle timeout partial flush
    @(posedge clk);
    #1 tmo = 16'd20;
    push(8'hA5); push(8'h5A);
    wait_wvalid("B_seen");
    chk("B_tmo_lat", cyc - last_pop, 23);
    chk("B_wdata", wdata, 32'h00005AA5);
    chk("B_wcnt", wcnt, 2);
    @(posedge clk);
    #1 tmo = 0;
    push(8'h10); push(8'h20);
    n = 0;
    repeat (100) @(negedge clk) n += int'(wvalid);
    chk("B_no_tmo", n, 0);
    @(posedge clk);
    #1 en = 0;
    wait_wvalid("B_dis_seen");
    chk("B_dis_wdata", wdata, 32'h00002010);
    chk("B_dis_wcnt", wcnt, 2);
    // consumer stall with FIFO non-empty, then flush on disable
    @(posedge clk);
    #1 en = 1; wready = 0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    push(8'h01); push(8'h02); push(8'h03);
    wait_wvalid("C_seen");
    p0 = pops;
    repeat (10) @(negedge clk);
    chk("C_stall_valid", wvalid, 1);
    chk("C_stall_wdata", wdata, 32'hC4C3C2C1);
    chk("C_stall_wcnt", wcnt, 4);
    chk("C_no_pop", pops, p0);
    chk("C_fifo_kept", q.size(), 3);
    @(posedge clk);
    #1 wready = 1;
    for (int i = 0; i < 100 && pops < p0 + 3; i++) @(negedge clk);
    chk("C_resume", pops - p0, 3);
    repeat (2) @(posedge clk);
    #1 en = 0;
    wait_wvalid("E_seen");
    chk("E_wdata", wdata, 32'h00030201);
    chk("E_wcnt", wcnt, 3);
    p0 = pops;
    @(posedge clk);
    #1 push(8'h55);
    repeat (20) @(negedge clk);
    chk("E_no_pop_dis", pops, p0);
    q.delete();
    // reset during CAPT discards the partial word
    @(posedge clk);
    #1 en = 1;
    push(8'h77); push(8'h88);
    for (int i = 0; i < 50 && !rdrxd; i++) @(negedge clk);
    chk("D_pop_seen", rdrxd, 1);
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk("D_rst_wvalid", wvalid, 0);
    chk("D_rst_wdata", wdata, 0);
    chk("D_rst_wcnt", wcnt, 0);
    chk("D_rst_rdrxd", rdrxd, 0);
    chk("D_rst_rxen_n", rxen_n, 1);
    chk("D_rst_divp", divp, 0);
    @(posedge clk);
    #1 rst = 1;
    push(8'h99); push(8'hAA); push(8'hBB);
    wait_wvalid("D_seen");
    chk("D_wdata", wdata, 32'hBBAA9988);
    chk("D_wcnt", wcnt, 4);
    // randomized traffic against the byte-stream scoreboard
    @(posedge clk);
    #1 sb_on = 1;
    tmo = 16'($urandom_range(5, 40));
    sent = 0;
    repeat (1500) begin
      @(posedge clk);
      #1 wready = ($urandom_range(0, 3) != 0);
      if (sent < 60 && q.size() < 12 && $urandom_range(0, 2) == 0) begin
        push(8'($urandom));
        sent++;
      end
    end
    wready = 1;
    for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1 en = 0;
    repeat (30) @(negedge clk);
    chk("R_fifo_empty", q.size(), 0);
    chk("R_drained", exp_q.size(), 0);
    chk("R_idle", wvalid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_drain.md
Name: uart_rx_drain

Overview:
- Sequencer sitting between the 8N1 receiver (with its 15-entry rx FIFO) and the host-side consumer.
- Programs the receiver: enable and baud divisor.
- Drains the rx FIFO one byte at a time and packs bytes little-endian into 32-bit words.
- Presents words on a valid/ready interface; an idle timeout flushes partial words.
- Tracks FIFO-full overflow risk in a sticky flag.

Parameters:
- TMO_W, 16, width of the timeout counter and of the tmo port.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  1 = drain/receive enabled
- divp_in  in  16  requested baud divisor, in clocks per bit
- tmo  in  TMO_W  idle-flush timeout in clk cycles; 0 = timeout disabled
- rxen_n  out  1  receiver enable, active-low (0 = receive)
- divp  out  16  divisor driven to the receiver
- rdrxd  out  1  FIFO pop strobe, one clk wide
- dat  in  8  FIFO read data, valid the cycle after the rdrxd pulse
- rxempty  in  1  1 = FIFO empty
- rxfull  in  1  1 = FIFO full
- wdata  out  32  packed word; byte0 = first received, in bits [7:0]
- wcnt  out  3  number of valid bytes in wdata, 1..4; 0 when wvalid=0
- wvalid  out  1  word valid
- wready  in  1  consumer accepts the word
- ovf  out  1  sticky: FIFO full was observed
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset values: rxen_n=1, divp=0, rdrxd=0, wdata=0, wcnt=0, wvalid=0, ovf=0, state=IDLE, byte count bcnt=0, timeout counter tcnt=0.
- Configuration:
  - While en=0, divp <= divp_in every cycle.
  - While en=1, divp is frozen.
  - rxen_n <= ~en, registered, so it trails en by 1 cycle.
- States: IDLE, POP, CAPT, EMIT.
- IDLE:
  - If en=1, rxempty=0 and bcnt<4: go to POP.
  - Else if bcnt=4: go to EMIT.
  - Else if bcnt>0, tmo!=0 and tcnt==tmo: go to EMIT (partial flush).
  - Else if bcnt>0 and en=0: go to EMIT (flush on disable).
  - tcnt increments each IDLE cycle while bcnt>0, saturating at all-ones. It holds at 0 while bcnt=0.
- POP: rdrxd=1 for exactly this cycle, then go to CAPT.
- CAPT:
  - wdata[8*bcnt +: 8] <= dat; bcnt <= bcnt+1; tcnt <= 0; go to IDLE.
- Pop rate: at most one pop per 3 cycles.
  - Latency from rxempty falling (IDLE) to byte captured: 2 cycles.
- EMIT:
  - wvalid=1 and wcnt=bcnt.
  - wdata and wcnt stay stable until wready=1.
  - On the wvalid & wready cycle: wvalid<=0, wdata<=0, bcnt<=0, tcnt<=0, go to IDLE.
  - No pops occur during EMIT.
- No pop is ever issued when rxempty=1 or bcnt=4.
- en falling mid-POP/CAPT: the in-flight byte completes capture, then the flush rule applies.
- ovf:
  - Set on any cycle with rxfull=1; cleared by ovf_clr.
  - Set and clear in the same cycle: set wins.
- Reset asserted mid-operation: all state returns to reset values immediately. The partial word is discarded and no wvalid is produced.

Test Plan:
- divp_in=16'd434, en=0 -> divp=434, rxen_n=1. Raise en, then change divp_in to 100 -> divp stays 434 and rxen_n=0 one cycle after en.
- FIFO preloaded 0x11,0x22,0x33,0x44, wready=1, tmo=0 -> four single-cycle rdrxd pulses, then wdata=0x44332211, wcnt=4, wvalid for exactly 1 cycle.
- Two bytes 0xA5,0x5A, tmo=20, FIFO then empty -> wvalid rises 21 cycles after the second capture, with wdata=0x00005AA5 and wcnt=2. With tmo=0, no emit occurs.
- wready held 0 for 10 cycles during EMIT with FIFO non-empty -> wvalid, wdata and wcnt stable; zero rdrxd pulses. After the wready pulse, draining resumes.
- en dropped after 3 bytes captured (0x01,0x02,0x03) -> emit wdata=0x00030201, wcnt=3; no further pops while en=0.
- rxfull pulsed 1 cycle -> ovf=1 and holds. ovf_clr together with rxfull -> ovf stays 1. ovf_clr alone -> ovf=0.
- rst pulsed low during CAPT -> all outputs at reset values; the next word starts at bcnt=0.
